stepper_phase_decoder: RTL and testbench
========================================

# stepper_phase_decoder

Monitors the 4-bit coil-drive pattern of the ULN2003 stepper interface (IN1..IN4, half-step sequence) and reconstructs motion from it: step events, direction, signed position, sequence errors and stall. It is the read side of the stepper drive path. It sits on the motor pins (or an external loop-back of them) for closed-loop checking of the color-sorter drum position.

## Interface
- `POS_WIDTH`, 16: width of the signed position counter.
- `STABLE_CYCLES`, 4: consecutive identical synchronized samples required before a pattern is accepted. Minimum 1.
- `STALL_CYCLES`, 1_000_000: cycles without a step, while locked, before `stalled` asserts. 32-bit.
- `clk` in 1: FPGA clock.
- `rst` in 1: synchronous, active-high reset.
- `phase_in` in 4: observed coil pattern, asynchronous to `clk`.
- `clear` in 1: synchronous. Zeroes `position`, `error_count` and `seq_error`.
- `position` out POS_WIDTH: signed step count, two's complement.
- `step_pulse` out 1: one-cycle pulse per legal half-step.
- `dir` out 1: direction of the last legal step (1 = index +1, 0 = index −1).
- `step_index` out 3: index of the current accepted pattern.
- `locked` out 1: a valid reference pattern has been acquired.
- `seq_error` out 1: one-cycle pulse on an illegal transition or pattern.
- `error_count` out 8: error counter, saturates at 255.
- `stalled` out 1: no step for `STALL_CYCLES` cycles while locked.

## Operation
- **Pattern decode.** 1000=0, 1100=1, 0100=2, 0110=3, 0010=4, 0011=5, 0001=6, 1001=7.
  - 0000 means de-energized. It is ignored: no step, no error, state and index held.
  - Any other pattern is invalid.
- **Filter.** `phase_in` passes through a 2-flop synchronizer. The synchronized value must be equal on `STABLE_CYCLES` consecutive edges and differ from the last accepted pattern to be accepted. Shorter glitches are discarded silently.
- **FSM states:** UNLOCKED, LOCKED, STALLED. Reset state is UNLOCKED.
  - UNLOCKED + accepted valid pattern: load `step_index`, go to LOCKED, set `locked`=1. No step is counted.
  - LOCKED/STALLED + accepted valid pattern: compute delta = (new − old) mod 8.
    - delta=1: step forward, `position`+1, `dir`=1.
    - delta=7: step backward, `position`−1, `dir`=0.
    - delta 2..6: error. `step_index` loads the new index, `position` is unchanged.
    - After any of these, the state is LOCKED.
  - Accepted invalid pattern (any state): error. Index and state are unchanged.
  - LOCKED: the stall counter counts cycles since the last legal step or lock. On reaching `STALL_CYCLES`, go to STALLED and set `stalled`=1.
  - STALLED: a legal step clears `stalled` and is counted normally.
  - An error in STALLED returns to LOCKED and restarts the stall counter.
- **Arithmetic.**
  - `position` wraps modulo 2^POS_WIDTH.
  - `error_count` saturates at 255. Pulses after saturation still assert `seq_error`.
- **`clear`.**
  - Takes priority over a step or error in the same cycle: `position`=0 and `error_count`=0.
  - `step_pulse`, `dir` and `step_index` still update.
  - Lock and stall state are unaffected.
- **Reset mid-operation.** All state returns to reset values and any partially filtered pattern is discarded.

## Timing
- Reset values:
  - All outputs are 0: `position`, `step_pulse`, `dir`, `step_index`, `locked`, `seq_error`, `error_count`, `stalled`.
  - FSM is UNLOCKED, synchronizer flops are 0000, accepted pattern is 0000.
- Latency: a new `phase_in` value first sampled at edge E and held steady is accepted at edge E+1+`STABLE_CYCLES`.
  - Registered outputs (`step_pulse`, `position`, `dir`, `step_index`, `locked`, `seq_error`, `error_count`) change at edge E+2+`STABLE_CYCLES`. This is 6 edges with defaults.
- `step_pulse` and `seq_error` are high for exactly one cycle per accepted event. They are never high together.
- Back-to-back legal steps are accepted at most once per `STABLE_CYCLES` cycles. Faster input is filtered, not queued.
- `stalled` asserts on the cycle the counter reaches `STALL_CYCLES`. It deasserts in the same cycle `step_pulse` asserts.

## Structure
- Shared package `stepper_pkg` (also used by the drive block) holds:
  - the 8-entry half-step pattern constants;
  - a pattern→{valid, index} decode function;
  - the FSM state enum;
  - the idle pattern constant 4'b0000.
- Sub-module `phase_input_filter` contains the 2-flop synchronizer and the `STABLE_CYCLES` qualifier. It outputs an `accept` strobe plus the 4-bit pattern.
- The top level contains decode, FSM, position, error and stall counters.

## Test plan
- **Lock.** After reset, hold 1000: at edge 6, `locked`=1, `step_index`=0, `position`=0, no `step_pulse`.
- **Forward revolution.** 1000→1100→…→1001→1000, each held 10 cycles: 8 `step_pulse`, `position`=8, `dir`=1, `error_count`=0.
- **Reverse.** From 1000 locked, 1001 then 0001: `position`=0xFFFE, `dir`=0, `step_index`=6.
- **Glitch and idle.**
  - Locked at 1000, 1100 held 2 cycles then back to 1000: no pulse, `position` unchanged.
  - Insert 0000 held 20 cycles: no change.
- **Errors.**
  - Locked at 1000, apply 0110: one `seq_error`, `error_count`=1, `step_index`=3, `position` unchanged.
  - Then apply 1111: `error_count`=2, `step_index`=3.
  - Then 256 more forced errors: `error_count` holds at 255.
- **Stall and clear** (`STALL_CYCLES`=100).
  - Hold 1000 after lock: `stalled`=1 exactly 100 cycles after lock.
  - Apply 1100: `stalled`=0, `position`=1.
  - Assert `clear` on the cycle of the next step: `position`=0, `step_pulse`=1.

Source files
------------

// File: rtl/stepper_pkg.sv
// stepper_pkg
//   Shared definitions for the ULN2003 half-step drive path (drive and read
//   sides): the eight half-step coil patterns, the de-energized pattern,
//   a pattern -> {valid, index} decoder and the phase decoder FSM states.
package stepper_pkg;

  localparam logic [3:0] PAT_IDLE  = 4'b0000;
  localparam logic [3:0] PAT_STEP0 = 4'b1000;
  localparam logic [3:0] PAT_STEP1 = 4'b1100;
  localparam logic [3:0] PAT_STEP2 = 4'b0100;
  localparam logic [3:0] PAT_STEP3 = 4'b0110;
  localparam logic [3:0] PAT_STEP4 = 4'b0010;
  localparam logic [3:0] PAT_STEP5 = 4'b0011;
  localparam logic [3:0] PAT_STEP6 = 4'b0001;
  localparam logic [3:0] PAT_STEP7 = 4'b1001;

  typedef enum logic [1:0] {
    ST_UNLOCKED = 2'd0,
    ST_LOCKED   = 2'd1,
    ST_STALLED  = 2'd2
  } phase_state_e;

  typedef struct packed {
    logic       valid;
    logic [2:0] index;
  } phase_decode_t;

  // Index -> coil pattern, used by the drive side.
  function automatic logic [3:0] step_pattern(input logic [2:0] index);
    logic [3:0] pat;
    case (index)
      3'd0:    pat = PAT_STEP0;
      3'd1:    pat = PAT_STEP1;
      3'd2:    pat = PAT_STEP2;
      3'd3:    pat = PAT_STEP3;
      3'd4:    pat = PAT_STEP4;
      3'd5:    pat = PAT_STEP5;
      3'd6:    pat = PAT_STEP6;
      default: pat = PAT_STEP7;
    endcase
    return pat;
  endfunction

  // Coil pattern -> {valid, index}. The idle pattern decodes as invalid;
  // callers filter it out before using the result.
  function automatic phase_decode_t decode_phase(input logic [3:0] pattern);
    phase_decode_t d;
    d.valid = 1'b1;
    d.index = 3'd0;
    case (pattern)
      PAT_STEP0: d.index = 3'd0;
      PAT_STEP1: d.index = 3'd1;
      PAT_STEP2: d.index = 3'd2;
      PAT_STEP3: d.index = 3'd3;
      PAT_STEP4: d.index = 3'd4;
      PAT_STEP5: d.index = 3'd5;
      PAT_STEP6: d.index = 3'd6;
      PAT_STEP7: d.index = 3'd7;
      default:   d.valid = 1'b0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/stepper_phase_decoder_filter.sv
// phase_input_filter
//   Brings the asynchronous coil pattern into the clk domain through a
//   2-flop synchronizer, then qualifies it: a pattern is accepted once the
//   synchronized value has been identical on STABLE_CYCLES consecutive edges
//   and differs from the previously accepted pattern. Shorter glitches are
//   dropped without any indication.
// Ports:
//   clk_i      clock
//   rst_i      synchronous active-high reset
//   phase_i    raw coil pattern (asynchronous)
//   accept_o   one-cycle strobe, pattern_o holds a newly accepted pattern
//   pattern_o  last accepted pattern
module phase_input_filter #(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [3:0] phase_i,
  output logic       accept_o,
  output logic [3:0] pattern_o
);

  localparam int unsigned     CNT_W   = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [3:0]       sync1_q, sync2_q;
  logic [3:0]       cand_q, cand_d;
  logic [3:0]       acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             accept_q, accept_d;

  // cnt counts how many consecutive edges sync2_q has shown cand. It
  // saturates at STABLE_CYCLES so a long-held pattern cannot re-trigger;
  // the "differs from accepted" test blocks repeats of the same pattern.
  always_comb begin
    cand_d   = cand_q;
    cnt_d    = cnt_q;
    if (sync2_q != cand_q) begin
      cand_d = sync2_q;
      cnt_d  = CNT_ONE;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d  = cnt_q + CNT_ONE;
    end
    accept_d = (cnt_d == CNT_MAX) && (cand_d != acc_q);
    acc_d    = accept_d ? cand_d : acc_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q  <= 4'b0000;
      sync2_q  <= 4'b0000;
      cand_q   <= 4'b0000;
      acc_q    <= 4'b0000;
      cnt_q    <= '0;
      accept_q <= 1'b0;
    end else begin
      sync1_q  <= phase_i;
      sync2_q  <= sync1_q;
      cand_q   <= cand_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      accept_q <= accept_d;
    end
  end

  assign accept_o  = accept_q;
  assign pattern_o = acc_q;

endmodule

// File: rtl/stepper_phase_decoder.sv
// stepper_phase_decoder
//   Read side of the stepper drive path. Watches the ULN2003 coil pattern
//   and reconstructs half-step motion: step pulses, direction, a signed
//   position count, sequence errors and stall detection.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   phase_in      observed coil pattern (asynchronous)
//   clear         zeroes position, error_count and seq_error
//   position      signed step count (two's complement, wraps)
//   step_pulse    one-cycle pulse per legal half-step
//   dir           direction of last legal step (1 = index +1)
//   step_index    index of current accepted pattern
//   locked        a valid reference pattern has been acquired
//   seq_error     one-cycle pulse per illegal transition or pattern
//   error_count   saturating error counter
//   stalled       no step for STALL_CYCLES cycles while locked
//   fsm_state     debug view of the FSM state (phase_state_e encoding)
// Handshake: accept from the filter is a single-cycle strobe with no
// back-pressure; every accepted pattern is consumed in the cycle it appears.
module stepper_phase_decoder
  import stepper_pkg::*;
#(
  parameter int unsigned POS_WIDTH     = 16,
  parameter int unsigned STABLE_CYCLES = 4,
  parameter logic [31:0] STALL_CYCLES  = 32'd1_000_000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [3:0]           phase_in,
  input  logic                 clear,
  output logic [POS_WIDTH-1:0] position,
  output logic                 step_pulse,
  output logic                 dir,
  output logic [2:0]           step_index,
  output logic                 locked,
  output logic                 seq_error,
  output logic [7:0]           error_count,
  output logic                 stalled,
  output logic [1:0]           fsm_state
);

  localparam logic [POS_WIDTH-1:0] POS_ONE = POS_WIDTH'(1);

  logic          accept;
  logic [3:0]    acc_pat;
  phase_decode_t dec;
  logic [2:0]    delta;

  phase_state_e         state_q, state_d;
  logic [2:0]           idx_q, idx_d;
  logic [POS_WIDTH-1:0] pos_q, pos_d;
  logic                 dir_q, dir_d;
  logic                 step_q, step_d;
  logic                 err_q, err_d;
  logic [7:0]           err_cnt_q, err_cnt_d;
  logic [31:0]          stall_cnt_q, stall_cnt_d;
  logic                 restart;

  phase_input_filter #(
    .STABLE_CYCLES(STABLE_CYCLES)
  ) u_filter (
    .clk_i    (clk),
    .rst_i    (rst),
    .phase_i  (phase_in),
    .accept_o (accept),
    .pattern_o(acc_pat)
  );

  assign dec   = decode_phase(acc_pat);
  assign delta = dec.index - idx_q;  // modulo-8 by width

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    pos_d       = pos_q;
    dir_d       = dir_q;
    step_d      = 1'b0;
    err_d       = 1'b0;
    err_cnt_d   = err_cnt_q;
    stall_cnt_d = stall_cnt_q;
    restart     = 1'b0;

    // The idle (de-energized) pattern is ignored entirely.
    if (accept && (acc_pat != PAT_IDLE)) begin
      if (!dec.valid) begin
        err_d = 1'b1;
        if (state_q == ST_STALLED) begin
          state_d = ST_LOCKED;
          restart = 1'b1;
        end
      end else if (state_q == ST_UNLOCKED) begin
        idx_d   = dec.index;
        state_d = ST_LOCKED;
        restart = 1'b1;
      end else begin
        case (delta)
          3'd0: begin
            // Same index re-accepted (e.g. after an idle gap): no motion.
          end
          3'd1: begin
            step_d  = 1'b1;
            dir_d   = 1'b1;
            pos_d   = pos_q + POS_ONE;
            idx_d   = dec.index;
            state_d = ST_LOCKED;
            restart = 1'b1;
          end
          3'd7: begin
            step_d  = 1'b1;
            dir_d   = 1'b0;
            pos_d   = pos_q - POS_ONE;
            idx_d   = dec.index;
            state_d = ST_LOCKED;
            restart = 1'b1;
          end
          default: begin
            err_d   = 1'b1;
            idx_d   = dec.index;
            state_d = ST_LOCKED;
            restart = 1'b1;
          end
        endcase
      end
    end

    // Stall counter only runs while LOCKED; it holds once STALLED.
    if (restart) begin
      stall_cnt_d = '0;
    end else if (state_q == ST_LOCKED) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
      if (stall_cnt_d == STALL_CYCLES) state_d = ST_STALLED;
    end

    if (err_d && (err_cnt_q != 8'hFF)) err_cnt_d = err_cnt_q + 8'd1;

    // clear wins over the arithmetic of a same-cycle event, but the
    // step pulse, direction and index still reflect that event.
    if (clear) begin
      pos_d     = '0;
      err_cnt_d = '0;
      err_d     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_UNLOCKED;
      idx_q       <= 3'd0;
      pos_q       <= '0;
      dir_q       <= 1'b0;
      step_q      <= 1'b0;
      err_q       <= 1'b0;
      err_cnt_q   <= 8'd0;
      stall_cnt_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      pos_q       <= pos_d;
      dir_q       <= dir_d;
      step_q      <= step_d;
      err_q       <= err_d;
      err_cnt_q   <= err_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign position    = pos_q;
  assign step_pulse  = step_q;
  assign dir         = dir_q;
  assign step_index  = idx_q;
  assign locked      = (state_q != ST_UNLOCKED);
  assign seq_error   = err_q;
  assign error_count = err_cnt_q;
  assign stalled     = (state_q == ST_STALLED);
  assign fsm_state   = state_q;

endmodule

// File: tb/tb_stepper_phase_decoder.sv
// Testbench for stepper_phase_decoder (STALL_CYCLES = 100).
module tb_stepper_phase_decoder;
  import stepper_pkg::*;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  phase_in = 4'b0000;
  logic        clear = 1'b0;
  logic [15:0] position;
  logic        step_pulse, dir, locked, seq_error, stalled;
  logic [2:0]  step_index;
  logic [7:0]  error_count;
  logic [1:0]  fsm_state;

  always #5 clk = ~clk;

  stepper_phase_decoder #(
    .POS_WIDTH(16), .STABLE_CYCLES(4), .STALL_CYCLES(32'd100)
  ) dut (
    .clk(clk), .rst(rst), .phase_in(phase_in), .clear(clear),
    .position(position), .step_pulse(step_pulse), .dir(dir),
    .step_index(step_index), .locked(locked), .seq_error(seq_error),
    .error_count(error_count), .stalled(stalled), .fsm_state(fsm_state)
  );

  int errors = 0;
  int checks = 0;

  // Pulse monitor, sampled 1 time unit after the active edge.
  int n_step = 0, n_err = 0, n_both = 0;
  always @(posedge clk) begin
    #1;
    if (step_pulse) n_step++;
    if (seq_error) n_err++;
    if (step_pulse && seq_error) n_both++;
  end

  // ---------------- reference model ----------------
  // Half-step table and transaction-level rules: a pattern held for at
  // least 4 cycles is one accepted event, shorter holds are nothing.
  logic [3:0] pat_tab [8] = '{4'b1000, 4'b1100, 4'b0100, 4'b0110,
                              4'b0010, 4'b0011, 4'b0001, 4'b1001};
  logic        m_locked, m_dir;
  int          m_idx, m_err, m_steps, m_errp;
  logic [15:0] m_pos;
  logic [3:0]  m_acc;

  function automatic int find_idx(input logic [3:0] p);
    for (int i = 0; i < 8; i++) if (pat_tab[i] == p) return i;
    return -1;
  endfunction

  task automatic model_error();
    if (m_err < 255) m_err++;
    m_errp++;
  endtask

  task automatic model_accept(input logic [3:0] p);
    int k, d;
    if (p == m_acc) return;
    m_acc = p;
    if (p == 4'b0000) return;
    k = find_idx(p);
    if (k < 0) begin model_error(); return; end
    if (!m_locked) begin m_locked = 1'b1; m_idx = k; return; end
    d = (k - m_idx + 8) % 8;
    if (d == 1) begin
      m_pos = m_pos + 16'd1; m_dir = 1'b1; m_steps++; m_idx = k;
    end else if (d == 7) begin
      m_pos = m_pos - 16'd1; m_dir = 1'b0; m_steps++; m_idx = k;
    end else if (d != 0) begin
      model_error(); m_idx = k;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic hold(input logic [3:0] p, input int n);
    phase_in = p;
    cyc(n);
  endtask

  task automatic drive_accepted(input logic [3:0] p, input int n);
    hold(p, n);
    model_accept(p);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; clear = 1'b0; phase_in = 4'b0000;
    cyc(3);
    rst = 1'b0;
    m_locked = 1'b0; m_dir = 1'b0; m_idx = 0; m_err = 0;
    m_pos = 16'd0; m_acc = 4'b0000;
    m_steps = n_step; m_errp = n_err;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    checks++; if (position !== 16'd0) begin errors++; $display("FAIL reset_position: got %0h expected 0", position); end
    checks++; if (step_pulse !== 1'b0) begin errors++; $display("FAIL reset_step_pulse: got %b expected 0", step_pulse); end
    checks++; if (dir !== 1'b0) begin errors++; $display("FAIL reset_dir: got %b expected 0", dir); end
    checks++; if (step_index !== 3'd0) begin errors++; $display("FAIL reset_step_index: got %0d expected 0", step_index); end
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL reset_locked: got %b expected 0", locked); end
    checks++; if (seq_error !== 1'b0) begin errors++; $display("FAIL reset_seq_error: got %b expected 0", seq_error); end
    checks++; if (error_count !== 8'd0) begin errors++; $display("FAIL reset_error_count: got %0d expected 0", error_count); end
    checks++; if (stalled !== 1'b0) begin errors++; $display("FAIL reset_stalled: got %b expected 0", stalled); end
    checks++; if (fsm_state !== ST_UNLOCKED) begin errors++; $display("FAIL reset_state: got %0d expected %0d", fsm_state, ST_UNLOCKED); end
    // Partially filtered pattern interrupted by reset must not lock.
    phase_in = 4'b1000;
    cyc(4);
    do_reset();
    cyc(12);
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL reset_mid_locked: got %b expected 0", locked); end
  endtask

  task automatic test_lock();
    do_reset();
    phase_in = 4'b1000;
    cyc(6);
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL lock_early: got %b expected 0", locked); end
    cyc(1);
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL lock_locked: got %b expected 1", locked); end
    checks++; if (step_index !== 3'd0) begin errors++; $display("FAIL lock_index: got %0d expected 0", step_index); end
    checks++; if (position !== 16'd0) begin errors++; $display("FAIL lock_position: got %0h expected 0", position); end
    checks++; if (fsm_state !== ST_LOCKED) begin errors++; $display("FAIL lock_state: got %0d expected %0d", fsm_state, ST_LOCKED); end
    model_accept(4'b1000);
    cyc(3);
    checks++; if (n_step !== m_steps) begin errors++; $display("FAIL lock_no_step: got %0d pulses expected %0d", n_step, m_steps); end
  endtask

  task automatic test_forward();
    for (int i = 1; i <= 8; i++) drive_accepted(pat_tab[i % 8], 10);
    checks++; if (n_step - m_steps + 8 !== 8 || m_steps !== n_step) begin errors++; $display("FAIL fwd_pulses: got %0d expected %0d", n_step, m_steps); end
    checks++; if (position !== 16'd8) begin errors++; $display("FAIL fwd_position: got %0h expected 8", position); end
    checks++; if (dir !== 1'b1) begin errors++; $display("FAIL fwd_dir: got %b expected 1", dir); end
    checks++; if (error_count !== 8'd0) begin errors++; $display("FAIL fwd_error_count: got %0d expected 0", error_count); end
    checks++; if (step_index !== 3'd0) begin errors++; $display("FAIL fwd_index: got %0d expected 0", step_index); end
  endtask

  task automatic test_reverse();
    do_reset();
    drive_accepted(4'b1000, 10);
    drive_accepted(4'b1001, 10);
    drive_accepted(4'b0001, 10);
    checks++; if (position !== 16'hFFFE) begin errors++; $display("FAIL rev_position: got %0h expected fffe", position); end
    checks++; if (dir !== 1'b0) begin errors++; $display("FAIL rev_dir: got %b expected 0", dir); end
    checks++; if (step_index !== 3'd6) begin errors++; $display("FAIL rev_index: got %0d expected 6", step_index); end
    checks++; if (n_step !== m_steps) begin errors++; $display("FAIL rev_pulses: got %0d expected %0d", n_step, m_steps); end
  endtask

  task automatic test_glitch_idle();
    int s0, e0;
    do_reset();
    drive_accepted(4'b1000, 10);
    s0 = n_step; e0 = n_err;
    hold(4'b1100, 2);
    hold(4'b1000, 10);
    hold(4'b1100, 3);
    hold(4'b1000, 10);
    checks++; if (n_step !== s0) begin errors++; $display("FAIL glitch_pulses: got %0d expected %0d", n_step, s0); end
    checks++; if (position !== 16'd0) begin errors++; $display("FAIL glitch_position: got %0h expected 0", position); end
    drive_accepted(4'b0000, 20);
    drive_accepted(4'b1000, 10);
    checks++; if (n_step !== s0 || n_err !== e0) begin errors++; $display("FAIL idle_pulses: got %0d/%0d expected %0d/%0d", n_step, n_err, s0, e0); end
    checks++; if (step_index !== 3'd0) begin errors++; $display("FAIL idle_index: got %0d expected 0", step_index); end
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL idle_locked: got %b expected 1", locked); end
    // Exactly STABLE_CYCLES of hold is enough to be accepted.
    drive_accepted(4'b1100, 4);
    drive_accepted(4'b1000, 10);
    checks++; if (n_step !== s0 + 2) begin errors++; $display("FAIL min_hold_pulses: got %0d expected %0d", n_step, s0 + 2); end
    checks++; if (position !== 16'd0) begin errors++; $display("FAIL min_hold_position: got %0h expected 0", position); end
  endtask

  task automatic test_errors();
    do_reset();
    drive_accepted(4'b1000, 10);
    drive_accepted(4'b0110, 10);
    checks++; if (n_err !== m_errp || m_errp - n_err + 1 !== 1) begin errors++; $display("FAIL err_pulse: got %0d expected %0d", n_err, m_errp); end
    checks++; if (error_count !== 8'd1) begin errors++; $display("FAIL err_count1: got %0d expected 1", error_count); end
    checks++; if (step_index !== 3'd3) begin errors++; $display("FAIL err_index: got %0d expected 3", step_index); end
    checks++; if (position !== 16'd0) begin errors++; $display("FAIL err_position: got %0h expected 0", position); end
    drive_accepted(4'b1111, 10);
    checks++; if (error_count !== 8'd2) begin errors++; $display("FAIL err_count2: got %0d expected 2", error_count); end
    checks++; if (step_index !== 3'd3) begin errors++; $display("FAIL err_index2: got %0d expected 3", step_index); end
    for (int i = 0; i < 256; i++) drive_accepted((i % 2 == 0) ? 4'b1110 : 4'b1111, 6);
    cyc(4);
    checks++; if (error_count !== 8'd255) begin errors++; $display("FAIL err_saturate: got %0d expected 255", error_count); end
    checks++; if (n_err !== m_errp) begin errors++; $display("FAIL err_pulses_after_sat: got %0d expected %0d", n_err, m_errp); end
  endtask

  task automatic test_stall_clear();
    int cnt;
    do_reset();
    phase_in = 4'b1000;
    cnt = 0;
    while (!locked && cnt < 30) begin cyc(1); cnt++; end
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL stall_lock_timeout: got %b expected 1", locked); end
    model_accept(4'b1000);
    cnt = 0;
    while (!stalled && cnt < 300) begin cyc(1); cnt++; end
    checks++; if (cnt !== 100) begin errors++; $display("FAIL stall_latency: got %0d cycles expected 100", cnt); end
    checks++; if (fsm_state !== ST_STALLED) begin errors++; $display("FAIL stall_state: got %0d expected %0d", fsm_state, ST_STALLED); end
    phase_in = 4'b1100;
    cnt = 0;
    while (!step_pulse && cnt < 30) begin cyc(1); cnt++; end
    checks++; if (step_pulse !== 1'b1) begin errors++; $display("FAIL stall_step_timeout: got %b expected 1", step_pulse); end
    checks++; if (stalled !== 1'b0) begin errors++; $display("FAIL stall_release: got %b expected 0", stalled); end
    checks++; if (position !== 16'd1) begin errors++; $display("FAIL stall_position: got %0h expected 1", position); end
    model_accept(4'b1100);
    cyc(5);
    // clear in the same cycle the next step registers
    phase_in = 4'b0100;
    cyc(6);
    clear = 1'b1;
    cyc(1);
    clear = 1'b0;
    model_accept(4'b0100);
    m_pos = 16'd0; m_err = 0;
    checks++; if (step_pulse !== 1'b1) begin errors++; $display("FAIL clear_step_pulse: got %b expected 1", step_pulse); end
    checks++; if (position !== m_pos) begin errors++; $display("FAIL clear_position: got %0h expected %0h", position, m_pos); end
    checks++; if (step_index !== 3'd2) begin errors++; $display("FAIL clear_index: got %0d expected 2", step_index); end
    // clear wipes an accumulated error count but not lock
    drive_accepted(4'b1111, 10);
    checks++; if (error_count !== 8'd1) begin errors++; $display("FAIL clear_pre_errors: got %0d expected 1", error_count); end
    clear = 1'b1;
    cyc(1);
    clear = 1'b0;
    m_err = 0;
    checks++; if (error_count !== 8'd0) begin errors++; $display("FAIL clear_errors: got %0d expected 0", error_count); end
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL clear_locked: got %b expected 1", locked); end
  endtask

  task automatic test_back_to_back();
    int s0;
    do_reset();
    drive_accepted(4'b1000, 10);
    for (int i = 1; i <= 8; i++) drive_accepted(pat_tab[i % 8], 4);
    cyc(8);
    checks++; if (n_step !== m_steps) begin errors++; $display("FAIL b2b_pulses: got %0d expected %0d", n_step, m_steps); end
    checks++; if (position !== m_pos) begin errors++; $display("FAIL b2b_position: got %0h expected %0h", position, m_pos); end
    s0 = n_step;
    hold(4'b1100, 3);
    hold(4'b0100, 3);
    hold(4'b1000, 10);
    checks++; if (n_step !== s0) begin errors++; $display("FAIL b2b_fast_filtered: got %0d expected %0d", n_step, s0); end
    checks++; if (position !== m_pos) begin errors++; $display("FAIL b2b_fast_position: got %0h expected %0h", position, m_pos); end
  endtask

  task automatic test_random();
    logic [3:0] cur_p, p, g;
    int r, n;
    do_reset();
    cur_p = 4'b0000;
    for (int op = 0; op < 70; op++) begin
      r = $urandom_range(0, 99);
      if (r >= 88) begin
        do g = 4'($urandom_range(0, 15)); while (g == cur_p);
        hold(g, $urandom_range(1, 3));
        n = 10;
        hold(cur_p, n);
      end else begin
        if (r < 55) begin
          if (m_locked) p = pat_tab[(m_idx + (($urandom_range(0, 1) == 1) ? 1 : 7)) % 8];
          else p = pat_tab[$urandom_range(0, 7)];
        end else if (r < 68) begin
          do p = 4'($urandom_range(1, 15)); while (find_idx(p) >= 0);
        end else if (r < 78) begin
          p = 4'b0000;
        end else begin
          p = pat_tab[$urandom_range(0, 7)];
        end
        n = $urandom_range(4, 12);
        drive_accepted(p, n);
        cur_p = p;
      end
      if (n >= 7) begin
        checks++; if (position !== m_pos) begin errors++; $display("FAIL rnd_position op%0d: got %0h expected %0h", op, position, m_pos); end
        checks++; if (step_index !== 3'(m_idx)) begin errors++; $display("FAIL rnd_index op%0d: got %0d expected %0d", op, step_index, m_idx); end
        checks++; if (dir !== m_dir) begin errors++; $display("FAIL rnd_dir op%0d: got %b expected %b", op, dir, m_dir); end
        checks++; if (locked !== m_locked) begin errors++; $display("FAIL rnd_locked op%0d: got %b expected %b", op, locked, m_locked); end
        checks++; if (error_count !== 8'(m_err)) begin errors++; $display("FAIL rnd_error_count op%0d: got %0d expected %0d", op, error_count, m_err); end
        checks++; if (n_step !== m_steps) begin errors++; $display("FAIL rnd_pulses op%0d: got %0d expected %0d", op, n_step, m_steps); end
        checks++; if (n_err !== m_errp) begin errors++; $display("FAIL rnd_err_pulses op%0d: got %0d expected %0d", op, n_err, m_errp); end
      end
    end
    checks++; if (n_both !== 0) begin errors++; $display("FAIL pulse_overlap: got %0d cycles expected 0", n_both); end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_lock();
    test_forward();
    test_reverse();
    test_glitch_idle();
    test_errors();
    test_stall_clear();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1);
  end

endmodule
